// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: access sizes,
// FSM states and the byte-lane mask helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    // Lanes touched by an access within the low 32-bit group.
    function automatic logic [3:0] lane_mask(
        size_e      sz,
        logic [1:0] off
    );
        case (sz)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x DATA_W storage, synchronous byte-enabled write,
// combinational read. Ports: clk, we, be, addr, wdata, rdata.
module dmem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset so they survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctl.sv
// Data-memory controller: valid/ready request in, fixed-latency response out.
// Ports: clk, rst_n, req_* (valid/ready/we/size/addr/wdata), rsp_* (valid/ready/rdata/err).
// Optional macro DMEM_ERR_EN: fault misaligned/out-of-range/reserved-size
// accesses instead of wrapping and aligning them.
module dmem_ctl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB       = DATA_W / 8;
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic go_resp;
    logic accept;

    logic              we_q;
    logic [1:0]        size_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              c_we;
    logic [1:0]        c_size;
    logic [31:0]       c_addr;
    logic [DATA_W-1:0] c_wdata;

    size_e             sz;
    logic [29:0]       idx30;
    logic [1:0]        off;
    logic              fault;
    logic [NB-1:0]     be;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_ext;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the commit edge is the accept edge, so the
    // live request is used; otherwise the latched copy.
    assign c_we    = (state_q == IDLE) ? req_we    : we_q;
    assign c_size  = (state_q == IDLE) ? req_size  : size_q;
    assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign sz    = size_e'(c_size);
    assign idx30 = c_addr[31:2];

    always_comb begin
        off = 2'b00;
        case (sz)
            SZ_BYTE: off = c_addr[1:0];
            SZ_HALF: off = {c_addr[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

`ifdef DMEM_ERR_EN
    logic misal;
    logic oor;
    assign misal = (sz == SZ_HALF && c_addr[0])
                || (sz == SZ_WORD && c_addr[1:0] != 2'b00);
    assign oor   = (idx30 >= 30'(DEPTH));
    assign fault = misal || oor || (sz == SZ_RSVD);
`else
    assign fault = 1'b0;
`endif

    // Index always wrapped into range so the array is never
    // read outside 0..DEPTH-1, even on a faulting access.
    assign ram_addr = AW'(idx30 % 30'(DEPTH));

    always_comb begin
        be = '1;
        if (sz == SZ_BYTE || sz == SZ_HALF) begin
            be = NB'(lane_mask(sz, off));
        end
    end

    assign ram_we    = go_resp && c_we && !fault;
    assign ram_wdata = c_wdata << {off, 3'b000};
    assign rd_sh     = ram_rdata >> {off, 3'b000};

    always_comb begin
        rd_ext = rd_sh;
        case (sz)
            SZ_BYTE: rd_ext = DATA_W'(rd_sh[7:0]);
            SZ_HALF: rd_ext = DATA_W'(rd_sh[15:0]);
            default: rd_ext = rd_sh;
        endcase
    end

    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 3'(LAT_LOAD);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (go_resp) begin
                rsp_rdata <= (c_we || fault) ? '0 : rd_ext;
                rsp_err   <= fault;
            end
        end
    end

endmodule
